handshake_rx_unpacker: RTL
==========================

# handshake_rx_unpacker

Destination-domain consumer placed directly after the handshake synchronizer's destination side: watches its valid/data outputs and captures one WIDTH-bit word per transaction. It serializes the word into bytes, MSB first, on a valid/ready output port, optionally followed by an XOR checksum byte. It holds `busy` high while serializing so the synchronizer presents no new word.

## Interface
- `WIDTH`, 32: input word width; must be a multiple of 8; NB = WIDTH/8 bytes per word.
- `CHK_EN`, 1: 1 appends an XOR checksum byte after the NB payload bytes; 0 disables it.
- `clk`  in  1  destination clock (the synchronizer's `dclk`).
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `in_valid`  in  1  word-present level from the synchronizer (`dvalid`); may stay high for several cycles per word.
- `in_data`  in  WIDTH  word from the synchronizer (`dout`); sampled only in the capture cycle.
- `busy`  out  1  to the synchronizer's `dbusy`; high in every state except IDLE.
- `out_valid`  out  1  byte available.
- `out_data`  out  8  current byte.
- `out_ready`  in  1  downstream accepts the byte when high together with `out_valid`.
- `out_last`  out  1  high with the final byte of a word: checksum if CHK_EN, else byte NB-1.
- `word_cnt`  out  16  count of fully emitted words; wraps.

## Operation
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `word_cnt`=0, state IDLE, `in_valid` history register=0, byte index=0, checksum accumulator=0.
- Edge detect: the history register `v_d` updates to `in_valid` every cycle in all states. A capture event is `in_valid`=1 AND `v_d`=0 AND state==IDLE.
- An `in_valid` rise while not in IDLE is ignored. It is not queued, because `v_d` is already 1 on the next cycle.
- A level held high after returning to IDLE does not re-capture; a fresh 0→1 transition is required.
- States:
  - IDLE: wait for a capture event. On the event, latch `in_data` into the shift register, clear the byte index and checksum, then go to SEND.
  - SEND: present byte[idx] = word[WIDTH-1-8*idx -: 8].
    - On each accept, XOR the byte into the checksum and increment idx.
    - On accept of byte NB-1: go to CHK if CHK_EN, else go to IDLE.
  - CHK: present the checksum, defined as the XOR of all NB payload bytes. On accept, go to IDLE.
- `out_valid`=1 in SEND and CHK, 0 in IDLE. The byte and `out_valid` are held stable while `out_ready`=0; no byte is dropped or repeated.
- `out_last`=1 only on the final byte of a word, per the definition in the port list.
- `word_cnt` increments by 1 on the accept of the `out_last` byte; it wraps 0xFFFF→0.
- Reset mid-word: the partial word is discarded, `word_cnt` is unchanged from its value before reset (then cleared by reset), and every output returns to its reset value immediately (asynchronously).

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from `in_*` or `out_ready` to any output.
- Capture event at edge t → at t+1: state SEND, `busy`=1, `out_valid`=1, `out_data`=byte0.
- With `out_ready` held at 1: one byte per cycle. Bytes occupy cycles t+1 … t+NB, the checksum occupies t+NB+1 if CHK_EN, and `busy`=0 on the following cycle.
- Throughput at WIDTH=32: 5 cycles per word with checksum, 4 without. Minimum spacing between two captures adds one idle cycle plus whatever `in_valid` low time upstream needs.
- `busy` rises one cycle after the capture cycle. Upstream must tolerate this: the synchronizer's `dvalid` is itself registered, so this is sufficient.

## Test plan
- Reset, then `in_valid` pulse with `in_data`=0x12345678, `out_ready`=1, CHK_EN=1 → bytes 12,34,56,78,08 on consecutive cycles; `out_last` on 08; `word_cnt`=1; `busy` high exactly 5 cycles.
- `in_valid` held high 10 cycles with `in_data`=0xA5A5A5A5 → exactly one word emitted (A5,A5,A5,A5,00); no second capture while the level stays high.
- Same word, `out_ready` toggling 1,0,0,1,… → `out_data` stable during stalls; byte order and checksum unchanged; `word_cnt` increments once.
- Second `in_valid` rise during SEND → ignored; `word_cnt` counts 1. A later rise from IDLE with 0xDEADBEEF → DE,AD,BE,EF,22.
- `rst` asserted after byte 2 of a word → outputs 0 the same cycle; after release no residual bytes; a new word emits from byte0.
- 65536 back-to-back words with CHK_EN=0 → `word_cnt` wraps to 0; `out_last` on every 4th byte.

Source files
------------

// File: rtl/handshake_rx_unpacker.sv
// -----------------------------------------------------------------------------
// handshake_rx_unpacker
//
// Sits directly after the destination side of a handshake synchronizer. A
// rising edge of in_valid seen while idle captures one WIDTH-bit word. The word
// is then sent out MSB byte first on a valid/ready byte port. When CHK_EN is
// set, an XOR checksum byte of all payload bytes follows the payload. busy
// stays high while a word is in flight, so the synchronizer holds back the
// next word.
//
// Parameters
//   WIDTH     input word width, a multiple of 8 (NB = WIDTH/8 bytes)
//   CHK_EN    1: append checksum byte, 0: payload bytes only
//
// Ports
//   clk        in   destination clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   word-present level from the synchronizer
//   in_data    in   word from the synchronizer, sampled in the capture cycle
//   busy       out  high whenever a word is being serialized
//   out_valid  out  byte available
//   out_data   out  current byte
//   out_ready  in   downstream accepts the byte when high with out_valid
//   out_last   out  final byte of a word (checksum, or payload byte NB-1)
//   word_cnt   out  number of fully emitted words, wrapping
// -----------------------------------------------------------------------------
module handshake_rx_unpacker #(
    parameter int WIDTH  = 32,
    parameter bit CHK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      word_cnt
);

    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    // Index of the byte whose acceptance makes the next byte the final one.
    localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'((NB > 1) ? (NB - 2) : 0);
    localparam logic FIRST_IS_LAST = ((NB == 1) && (CHK_EN == 1'b0));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             v_d_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      word_cnt_q, word_cnt_d;

    logic             capture_s;
    logic             accept_s;
    logic [7:0]       chk_next_s;

    // A capture needs a fresh 0->1 edge of in_valid while idle.
    assign capture_s  = in_valid && !v_d_q && (state_q == ST_IDLE);
    assign accept_s   = out_valid_q && out_ready;
    assign chk_next_s = chk_q ^ out_data_q;

    // Next-state and next-output decode. The shift register holds the bytes
    // that are not yet presented, so the next byte is always its top byte.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    state_d     = ST_SEND;
                    shreg_d     = in_data << 8;
                    idx_d       = '0;
                    chk_d       = 8'h00;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data[WIDTH-1 -: 8];
                    out_last_d  = FIRST_IS_LAST;
                end else begin
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                    out_last_d  = 1'b0;
                end
            end

            ST_SEND: begin
                if (accept_s) begin
                    chk_d = chk_next_s;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        if (CHK_EN) begin
                            state_d     = ST_CHK;
                            out_data_d  = chk_next_s;
                            out_last_d  = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            busy_d      = 1'b0;
                            out_valid_d = 1'b0;
                            out_data_d  = 8'h00;
                            out_last_d  = 1'b0;
                            word_cnt_d  = word_cnt_q + 16'd1;
                        end
                    end else begin
                        shreg_d    = shreg_q << 8;
                        out_data_d = shreg_q[WIDTH-1 -: 8];
                        out_last_d = (idx_q == PEN_IDX) && (CHK_EN == 1'b0);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_CHK: begin
                if (accept_s) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                    out_last_d  = 1'b0;
                    word_cnt_d  = word_cnt_q + 16'd1;
                end else begin
                    state_d = ST_CHK;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            v_d_q       <= 1'b0;
            shreg_q     <= '0;
            idx_q       <= '0;
            chk_q       <= 8'h00;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            word_cnt_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            v_d_q       <= in_valid;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign word_cnt  = word_cnt_q;

endmodule
